song_sequencer: RTL and testbench

Sequences a stored tune through the single-note player by issuing one `note_start`/`note_done` handshake per note repetition. The tune lives in a small writable song table. Silent gaps are inserted between notes, and rests are timed without touching the player. The block sits between the board-level control (switches/keys) and the note player that drives the audio codec write path.

---
 rtl/song_seq_pkg.sv | 10 +
 rtl/song_sequencer_gap_timer.sv | 28 ++
 rtl/song_sequencer.sv | 118 +++++++++++
 tb/tb_song_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/song_seq_pkg.sv
// song_seq_pkg: shared state encoding, note-code constants and song-table entry layout
package song_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_RELEASE, S_GAP, S_END} state_t;
  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_END  = 4'd15;
  typedef struct packed {
    logic [3:0] note;
    logic [3:0] reps;
  } entry_t;
endpackage

// File: rtl/song_sequencer_gap_timer.sv
// gap_timer: loadable down-counter timing one silent gap or rest unit of CYCLES clocks
// Ports: start loads the counter, clear aborts it, expired is high in the final counted cycle.
module gap_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d;
  assign expired = run_q && cnt_q == '0;
  always_comb begin
    cnt_d = clear ? '0 : start ? CW'(CYCLES - 1) : (run_q && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    run_d = !clear && (start || (run_q && !expired));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: plays a writable song table through a note player, one handshake per repetition
// Ports: cfg_* write the table (IDLE only); go/halt/loop control playback; note_start/note_sel/
// note_done form the player handshake; busy, song_done and index report progress.
// Build option: define SONG_SEQ_LOOP_EN to let END restart from entry 0 while loop is high.
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter int SONG_LEN   = 16,
  parameter int GAP_CYCLES = 1000,
  parameter int IDX_W      = $clog2(SONG_LEN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [7:0]       cfg_data,
  input  logic             go,
  input  logic             halt,
  input  logic             loop,
  input  logic             note_done,
  output logic             note_start,
  output logic [3:0]       note_sel,
  output logic             busy,
  output logic             song_done,
  output logic [IDX_W-1:0] index
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [3:0] rep_q, rep_d, note_q, note_d;
  logic rest_q, rest_d, gap_start, gap_exp;
  entry_t table_q [SONG_LEN];
  entry_t entry;
`ifndef SONG_SEQ_LOOP_EN
  logic unused_loop;
  assign unused_loop = loop;
`endif
  gap_timer #(.CYCLES(GAP_CYCLES)) u_gap (
    .clk(clk), .reset_n(reset_n), .start(gap_start), .clear(halt), .expired(gap_exp)
  );
  assign note_start = state_q == S_PLAY;
  assign note_sel   = note_q;
  assign busy       = state_q != S_IDLE;
  assign song_done  = state_q == S_END;
  assign index      = index_q;
  assign entry      = table_q[index_q];
  always_ff @(posedge clk)
    if (cfg_we && state_q == S_IDLE) table_q[cfg_addr] <= cfg_data;
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    rep_d     = rep_q;
    note_d    = note_q;
    rest_d    = rest_q;
    gap_start = 1'b0;
    case (state_q)
      S_IDLE: if (go) begin
        state_d = S_FETCH;
        index_d = '0;
      end
      S_FETCH: begin
        rep_d  = entry.reps == 4'd0 ? 4'd1 : entry.reps;
        rest_d = entry.note == NOTE_REST;
        if (entry.note == NOTE_END) state_d = S_END;
        else if (entry.note == NOTE_REST) begin
          state_d   = S_GAP;
          gap_start = 1'b1;
        end else begin
          state_d = S_PLAY;
          note_d  = entry.note;
        end
      end
      S_PLAY: if (note_done) state_d = S_RELEASE;
      S_RELEASE: if (!note_done) begin
        state_d   = S_GAP;
        gap_start = 1'b1;
      end
      S_GAP: if (gap_exp) begin
        rep_d = rep_q - 4'd1;
        if (rep_q > 4'd1) begin
          state_d   = rest_q ? S_GAP : S_PLAY;
          gap_start = rest_q;
        end else if (index_q == IDX_W'(SONG_LEN - 1)) state_d = S_END;
        else begin
          state_d = S_FETCH;
          index_d = index_q + 1'b1;
        end
      end
      S_END: begin
`ifdef SONG_SEQ_LOOP_EN
        state_d = loop ? S_FETCH : S_IDLE;
        index_d = loop ? '0 : index_q;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (halt) begin
      state_d   = S_IDLE;
      rep_d     = '0;
      gap_start = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      index_q <= '0;
      rep_q   <= '0;
      note_q  <= '0;
      rest_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      rep_q   <= rep_d;
      note_q  <= note_d;
      rest_q  <= rest_d;
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed vector table plus hand sequences for halt, config, full table and reset
module tb_song_sequencer;
  localparam int G = 8;
`ifdef SONG_SEQ_LOOP_EN
  localparam bit LOOPS = 1'b1;
`else
  localparam bit LOOPS = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, cfg_we = 1'b0, go = 1'b0, halt = 1'b0, loop = 1'b0, note_done;
  logic [3:0] cfg_addr = '0, note_sel;
  logic [7:0] cfg_data = '0;
  logic note_start, busy, song_done;
  logic [3:0] index;
  int checks = 0, errors = 0, starts = 0, dones = 0, pcnt = 0, k;
  logic [3:0] last_sel = '0;
  logic prev_start = 1'b0;

  song_sequencer #(.SONG_LEN(16), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .go(go), .halt(halt), .loop(loop), .note_done(note_done), .note_start(note_start),
    .note_sel(note_sel), .busy(busy), .song_done(song_done), .index(index)
  );

  always #5 clk = ~clk;

  // player: raises note_done on the 5th falling edge of a held note_start, drops it once released
  initial begin
    note_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!note_start) begin
        note_done = 1'b0;
        pcnt = 0;
      end else if (pcnt == 4) note_done = 1'b1;
      else pcnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (note_start && !prev_start) begin
      starts++;
      last_sel = note_sel;
    end
    prev_start = note_start;
    if (song_done) dones++;
  end

  typedef struct {
    logic [7:0] e0, e1, e2;
    int starts;
    logic [3:0] note;
    int cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    starts = 0;
    dones = 0;
    last_sel = '0;
  endtask

  // returns falling edges from go's sampling edge until song_done is seen (0 on timeout)
  task automatic run_song(output int n);
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!song_done && n < 2000);
    if (!song_done) n = 0;
  endtask

  task automatic wait_note(input logic [3:0] sel);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(note_start && note_sel == sel) && n < 500);
    chk("wait_note", note_start && note_sel == sel, 1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h31, 8'hF0, 8'hF0, 1, 4'd3, 9 + G};
    vecs[1] = '{8'h23, 8'h02, 8'hF0, 3, 4'd2, 22 + 5 * G};
    vecs[2] = '{8'h50, 8'hF0, 8'hF0, 1, 4'd5, 9 + G};
    vecs[3] = '{8'hF0, 8'h11, 8'hF0, 0, 4'd0, 2};
    vecs[4] = '{8'h00, 8'hE2, 8'hF0, 2, 4'd14, 16 + 3 * G};
    repeat (3) @(negedge clk);
    chk("reset_start", note_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_index", index, 0);
    chk("reset_sel", note_sel, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_done", song_done, 0);

    for (int i = 0; i < 5; i++) begin
      wr(4'd0, vecs[i].e0);
      wr(4'd1, vecs[i].e1);
      wr(4'd2, vecs[i].e2);
      clr();
      run_song(k);
      chk($sformatf("v%0d_cycles", i), k, vecs[i].cyc);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_starts", i), starts, vecs[i].starts);
      chk($sformatf("v%0d_note", i), last_sel, vecs[i].note);
      chk($sformatf("v%0d_dones", i), dones, 1);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end

    // halt during the second note: immediate stop, no song_done, index restarts on next go
    wr(4'd0, 8'h11);
    wr(4'd1, 8'h71);
    wr(4'd2, 8'hF0);
    clr();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    wait_note(4'd7);
    chk("halt_index_before", index, 1);
    halt = 1'b1;
    @(posedge clk);
    #1;
    chk("halt_start", note_start, 0);
    chk("halt_busy", busy, 0);
    halt = 1'b0;
    repeat (G + 10) @(negedge clk);
    chk("halt_no_done", dones, 0);
    chk("halt_still_idle", busy, 0);
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    chk("halt_rego_index", index, 0);
    chk("halt_rego_busy", busy, 1);
    repeat (40) @(negedge clk);
    chk("halt_rego_done", dones, 1);

    // table writes while playing are dropped
    wr(4'd0, 8'h41);
    wr(4'd1, 8'hF0);
    clr();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    wait_note(4'd4);
    wr(4'd0, 8'h91);
    repeat (30) @(negedge clk);
    clr();
    run_song(k);
    chk("cfg_busy_cycles", k, 9 + G);
    repeat (2) @(negedge clk);
    chk("cfg_busy_note", last_sel, 4);

    // full table of notes, no end marker: ends after entry 15, loop ignored unless enabled
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h11);
    clr();
    loop = 1'b1;
    run_song(k);
    chk("full_cycles", k, 17 + 16 * (6 + G));
    chk("full_index", index, 15);
    chk("full_starts", starts, 16);
    @(negedge clk);
    chk("full_loop_busy", busy, LOOPS);
    chk("full_loop_index", index, LOOPS ? 0 : 15);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    loop = 1'b0;
    chk("full_halted", busy, 0);

    // asynchronous reset in the middle of the second note's gap
    wr(4'd0, 8'h11);
    wr(4'd1, 8'h31);
    wr(4'd2, 8'hF0);
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    wait_note(4'd3);
    repeat (10) @(negedge clk);
    chk("arst_pre_busy", busy, 1);
    chk("arst_pre_index", index, 1);
    chk("arst_pre_gap", note_start, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_index", index, 0);
    chk("arst_sel", note_sel, 0);
    chk("arst_start", note_start, 0);
    chk("arst_done", song_done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_after_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
